instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Instruction-side responder for the single-cycle CPU.
- The CPU presents its program counter on ADD[7:0] and expects Ins[7:0] back in the same cycle; this block holds the 256x8 program store that answers it.
- The program store is filled from board switches one byte per debounced button press.
- A mode switch selects LOAD or RUN. The block holds the CPU in reset whenever it is not in RUN.

Parameters:
- DEB_CYC, 250000: cycles a synchronized button/switch level must be stable before it is accepted. The bench overrides this to 4.
- CNT_W, 18: width of the debounce counters. It must satisfy 2^CNT_W > DEB_CYC.

Ports:
- CLK  input  1  system clock, single domain.
- RESET  input  1  synchronous, active-high reset.
- SW  input  8  instruction byte to store.
- STORE  input  1  raw push-button, asynchronous to CLK.
- RUN_SW  input  1  raw mode switch (1 = RUN, 0 = LOAD), asynchronous to CLK.
- ADD  input  8  CPU program-counter address.
- Ins  output  8  instruction to the CPU.
- CPU_RESET  output  1  active-high reset to the CPU.
- LPTR  output  8  next load address.
- FULL  output  1  program store full.
- RUNNING  output  1  block is in the RUN state.

Behaviour:
- Reset is synchronous and active-high: one clock (CLK); RESET is sampled on the rising edge of CLK only.
- Reset values of the outputs:
  - Ins = 8'h00
  - CPU_RESET = 1
  - LPTR = 0
  - FULL = 0
  - RUNNING = 0
- Reset clears both synchronizers, both debounce counters and the clear counter, and puts the state machine in CLEAR.
- Input conditioning:
  - STORE and RUN_SW each pass through a 2-flop synchronizer.
  - Each then goes through a debouncer. The debounced level changes only after the synchronized level has differed from it for DEB_CYC consecutive cycles. Any glitch restarts the count.
  - A rising edge of debounced STORE produces st_pulse, a single-cycle pulse.
- State machine states: CLEAR, LOAD, RUN.
- CLEAR state:
  - Writes 8'h00 to mem[clr_cnt] and increments clr_cnt each cycle, for addresses 0 through 255 (256 cycles).
  - After the write to address 255 it moves to LOAD.
  - st_pulse and RUN_SW are ignored in CLEAR.
  - RESET asserted mid-clear restarts the clear at address 0.
- LOAD state:
  - On st_pulse with FULL = 0, it writes SW to mem[LPTR] and LPTR wraps-free increments.
  - If that write was to address 255, FULL is set to 1 and LPTR stays at 255.
  - st_pulse with FULL = 1 is ignored: no write, no pointer change.
  - When debounced RUN_SW = 1, it moves to RUN.
  - If st_pulse and the RUN transition occur in the same cycle, the write is performed and the transition is also taken.
- RUN state:
  - The program store is read-only; st_pulse is ignored.
  - When debounced RUN_SW = 0, it returns to LOAD. LPTR and FULL are preserved, so further stores append to the program.
- Ins output:
  - In RUN, Ins = mem[ADD] as an asynchronous read. It changes combinationally with ADD and has zero latency, because the CPU is single-cycle.
  - In CLEAR and LOAD, Ins is forced to 8'h00.
- CPU_RESET and RUNNING are registered outputs:
  - CPU_RESET = (state != RUN)
  - RUNNING = (state == RUN)
  - Both update one cycle after the state changes. The CPU therefore leaves reset at the first CLK edge after RUNNING is observed as 1 internally. The CPU PC restarts at 0 on every LOAD-to-RUN entry.
- Only RESET resets LPTR and FULL. Only CLEAR writes zeros to memory.
- No other writes to the program store occur.

Test Plan:
- Reset then wait 256 cycles: CPU_RESET = 1 throughout and RUNNING = 0. Afterwards, sweeping ADD 0 through 255 in RUN returns Ins = 8'h00 for every address.
- Load three bytes in LOAD (SW = 8'h45, then 8'h9A, then 8'hC1; each press is held for 10 cycles with DEB_CYC = 4), then set RUN_SW = 1:
  - LPTR reads 1, 2, 3 after the respective presses.
  - After RUN is entered, ADD = 0, 1, 2 gives Ins = 8'h45, 8'h9A, 8'hC1.
  - CPU_RESET falls one cycle after RUNNING is set internally.
- Debounce: drive a STORE glitch of 2 cycles with DEB_CYC = 4. Expect no write and LPTR unchanged. Then hold STORE for 6 cycles: expect exactly one write and LPTR + 1. Holding STORE for 100 cycles still produces exactly one write.
- Full condition: perform 256 stores with SW equal to the index. Expect FULL = 1 and LPTR = 255 after the 256th store. A 257th store leaves mem[255] = 8'hFF unchanged. RUN read of ADD = 8'hFF returns 8'hFF.
- RUN-to-LOAD-to-RUN round trip: drop RUN_SW to 0. CPU_RESET returns to 1, Ins = 8'h00 and LPTR is preserved. A press with SW = 8'h77 writes mem[LPTR_old]. Back in RUN, the earlier bytes are intact.
- Mid-operation resets and same-cycle events:
  - RESET at clr_cnt = 100: expect the clear to restart at 0 and a full 256-cycle CLEAR.
  - st_pulse in the same cycle as the debounced RUN_SW rising: expect the byte written and RUN entered.

Source files
------------

// File: rtl/instr_loader_if.sv
// Board-side and CPU-side signals of the instruction loader, bundled so the
// loader and whatever drives it agree on direction through the modports.
interface instr_loader_if;
    logic [7:0] SW;
    logic       STORE;
    logic       RUN_SW;
    logic [7:0] ADD;
    logic [7:0] Ins;
    logic       CPU_RESET;
    logic [7:0] LPTR;
    logic       FULL;
    logic       RUNNING;

    modport master (
        output SW, STORE, RUN_SW, ADD,
        input  Ins, CPU_RESET, LPTR, FULL, RUNNING
    );

    modport slave (
        input  SW, STORE, RUN_SW, ADD,
        output Ins, CPU_RESET, LPTR, FULL, RUNNING
    );
endinterface

// File: rtl/instr_loader.sv
// Program store for a single-cycle CPU: cleared after reset, filled one byte
// per debounced button press in LOAD, read combinationally by the CPU in RUN.

module instr_loader_debounce #(
    parameter int unsigned DEB_CYC = 250000,
    parameter int unsigned CNT_W   = 18
) (
    input  logic CLK,
    input  logic RESET,
    input  logic raw_i,
    output logic level_o
);
    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The level flips only on the DEB_CYC-th consecutive cycle of disagreement;
    // any cycle of agreement drops the count back to zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (RESET) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
endmodule

module instr_loader #(
    parameter int unsigned DEB_CYC = 250000,
    parameter int unsigned CNT_W   = 18
) (
    input  logic           CLK,
    input  logic           RESET,
    instr_loader_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] clr_cnt_q, clr_cnt_d;
    logic [7:0] lptr_q, lptr_d;
    logic       full_q, full_d;
    logic       cpu_reset_q, running_q;
    logic       store_prev_q;

    logic       store_deb, run_deb, st_pulse;
    logic       mem_we;
    logic [7:0] mem_waddr, mem_wdata;
    logic [7:0] ins;

    logic [7:0] mem [256];

    instr_loader_debounce #(.DEB_CYC(DEB_CYC), .CNT_W(CNT_W)) u_store_deb (
        .CLK     (CLK),
        .RESET   (RESET),
        .raw_i   (bus.STORE),
        .level_o (store_deb)
    );

    instr_loader_debounce #(.DEB_CYC(DEB_CYC), .CNT_W(CNT_W)) u_run_deb (
        .CLK     (CLK),
        .RESET   (RESET),
        .raw_i   (bus.RUN_SW),
        .level_o (run_deb)
    );

    assign st_pulse = store_deb & ~store_prev_q;

    // State register; CPU_RESET/RUNNING follow the state one cycle late.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            lptr_q       <= '0;
            full_q       <= 1'b0;
            cpu_reset_q  <= 1'b1;
            running_q    <= 1'b0;
            store_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            lptr_q       <= lptr_d;
            full_q       <= full_d;
            cpu_reset_q  <= (state_q != ST_RUN);
            running_q    <= (state_q == ST_RUN);
            store_prev_q <= store_deb;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_cnt_q == 8'hFF) state_d = ST_LOAD;
            ST_LOAD:  if (run_deb)            state_d = ST_RUN;
            ST_RUN:   if (!run_deb)           state_d = ST_LOAD;
            default:                          state_d = ST_CLEAR;
        endcase
    end

    // A store in the same cycle as the LOAD->RUN transition is still honoured,
    // since the write decision looks only at the current state.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_cnt_q;
        mem_wdata = 8'h00;
        clr_cnt_d = clr_cnt_q;
        lptr_d    = lptr_q;
        full_d    = full_q;
        ins       = 8'h00;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + 8'd1;
            end
            ST_LOAD: begin
                if (st_pulse && !full_q) begin
                    mem_we    = 1'b1;
                    mem_waddr = lptr_q;
                    mem_wdata = bus.SW;
                    if (lptr_q == 8'hFF) begin
                        full_d = 1'b1;
                    end else begin
                        lptr_d = lptr_q + 8'd1;
                    end
                end
            end
            ST_RUN: begin
                ins = mem[bus.ADD];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: the program store has no reset; the CLEAR state zeroes it word by word instead.
        if (mem_we && !RESET) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.Ins       = ins;
    assign bus.CPU_RESET = cpu_reset_q;
    assign bus.RUNNING   = running_q;
    assign bus.LPTR      = lptr_q;
    assign bus.FULL      = full_q;
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with DEB_CYC = 4: clear, load, debounce,
// full, LOAD/RUN round trips, mid-clear reset and same-cycle store/run.
module tb_instr_loader;
    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    instr_loader_if bus ();

    instr_loader #(.DEB_CYC(4), .CNT_W(18)) dut (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {OP_PRESS, OP_MODE, OP_READ} op_e;
    typedef struct {
        op_e        op;
        logic [7:0] data;
        int         hold;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] d, input int hold);
        bus.SW    = d;
        bus.STORE = 1'b1;
        repeat (hold) tick();
        bus.STORE = 1'b0;
        repeat (10) tick();
    endtask

    // Two sync flops + four debounce cycles + state update + output register.
    task automatic set_mode(input logic v, input string tag);
        int n;
        bus.RUN_SW = v;
        n = 0;
        while (bus.RUNNING !== v && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_mode_latency"}, n, 8);
        check({tag, "_cpu_reset"}, bus.CPU_RESET, !v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.SW     = 8'h00;
        bus.STORE  = 1'b0;
        bus.RUN_SW = 1'b0;
        bus.ADD    = 8'h00;
        reset      = 1'b1;
        tick();
        tick();
        check("rst_ins",       bus.Ins,       8'h00);
        check("rst_cpu_reset", bus.CPU_RESET, 1);
        check("rst_lptr",      bus.LPTR,      0);
        check("rst_full",      bus.FULL,      0);
        check("rst_running",   bus.RUNNING,   0);

        // CLEAR: CPU held in reset throughout, button presses ignored.
        reset = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            bus.ADD   = 8'(i);
            bus.STORE = (i >= 10 && i < 30);
            tick();
            check($sformatf("clr%0d_cpu_reset", i), bus.CPU_RESET, 1);
            check($sformatf("clr%0d_running", i),   bus.RUNNING,   0);
            check($sformatf("clr%0d_ins", i),       bus.Ins,       8'h00);
        end
        check("clr_lptr", bus.LPTR, 0);

        set_mode(1'b1, "sweep_run");
        for (int a = 0; a < 256; a++) begin
            bus.ADD = 8'(a);
            #1;
            check($sformatf("sweep_ins_%0h", a), bus.Ins, 8'h00);
        end
        set_mode(1'b0, "sweep_load");
        check("sweep_load_ins", bus.Ins, 8'h00);

        // Load, debounce, ignored press in RUN and a LOAD/RUN round trip.
        vecs.push_back('{OP_PRESS, 8'h45, 10,  8'd1});
        vecs.push_back('{OP_PRESS, 8'h9A, 10,  8'd2});
        vecs.push_back('{OP_PRESS, 8'hC1, 10,  8'd3});
        vecs.push_back('{OP_MODE,  8'h01, 0,   8'd3});
        vecs.push_back('{OP_READ,  8'h00, 0,   8'h45});
        vecs.push_back('{OP_READ,  8'h01, 0,   8'h9A});
        vecs.push_back('{OP_READ,  8'h02, 0,   8'hC1});
        vecs.push_back('{OP_READ,  8'h03, 0,   8'h00});
        vecs.push_back('{OP_PRESS, 8'h33, 10,  8'd3});
        vecs.push_back('{OP_MODE,  8'h00, 0,   8'd3});
        vecs.push_back('{OP_PRESS, 8'hEE, 2,   8'd3});
        vecs.push_back('{OP_PRESS, 8'h11, 6,   8'd4});
        vecs.push_back('{OP_PRESS, 8'h22, 100, 8'd5});
        vecs.push_back('{OP_MODE,  8'h01, 0,   8'd5});
        vecs.push_back('{OP_READ,  8'h03, 0,   8'h11});
        vecs.push_back('{OP_READ,  8'h04, 0,   8'h22});
        vecs.push_back('{OP_READ,  8'h05, 0,   8'h00});
        vecs.push_back('{OP_MODE,  8'h00, 0,   8'd5});
        vecs.push_back('{OP_PRESS, 8'h77, 10,  8'd6});
        vecs.push_back('{OP_MODE,  8'h01, 0,   8'd6});
        vecs.push_back('{OP_READ,  8'h05, 0,   8'h77});
        vecs.push_back('{OP_READ,  8'h00, 0,   8'h45});
        vecs.push_back('{OP_READ,  8'h01, 0,   8'h9A});
        vecs.push_back('{OP_READ,  8'h02, 0,   8'hC1});
        vecs.push_back('{OP_READ,  8'h04, 0,   8'h22});
        vecs.push_back('{OP_MODE,  8'h00, 0,   8'd6});

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_PRESS: begin
                    press(vecs[i].data, vecs[i].hold);
                    check($sformatf("vec%0d_lptr", i), bus.LPTR, vecs[i].exp);
                    check($sformatf("vec%0d_full", i), bus.FULL, 0);
                end
                OP_MODE: begin
                    set_mode(vecs[i].data[0], $sformatf("vec%0d", i));
                    check($sformatf("vec%0d_lptr", i), bus.LPTR, vecs[i].exp);
                    if (!vecs[i].data[0]) begin
                        bus.ADD = 8'h00;
                        #1;
                        check($sformatf("vec%0d_load_ins", i), bus.Ins, 8'h00);
                    end
                end
                default: begin
                    bus.ADD = vecs[i].data;
                    #1;
                    check($sformatf("vec%0d_ins", i), bus.Ins, vecs[i].exp);
                end
            endcase
        end

        // Fill all 256 locations, then one more press against a full store.
        do_reset();
        repeat (260) tick();
        for (int i = 0; i < 256; i++) begin
            press(8'(i), 6);
            check($sformatf("fill%0d_lptr", i), bus.LPTR, (i < 255) ? i + 1 : 255);
            check($sformatf("fill%0d_full", i), bus.FULL, (i == 255) ? 1 : 0);
        end
        press(8'h00, 6);
        check("full_extra_lptr", bus.LPTR, 255);
        check("full_extra_full", bus.FULL, 1);
        set_mode(1'b1, "full_run");
        bus.ADD = 8'hFF; #1; check("full_ins_ff", bus.Ins, 8'hFF);
        bus.ADD = 8'h00; #1; check("full_ins_00", bus.Ins, 8'h00);
        bus.ADD = 8'h7F; #1; check("full_ins_7f", bus.Ins, 8'h7F);
        bus.ADD = 8'h80; #1; check("full_ins_80", bus.Ins, 8'h80);
        set_mode(1'b0, "full_load");

        // Store pulse and RUN switch debounced on the same cycle.
        do_reset();
        repeat (260) tick();
        bus.SW     = 8'hA5;
        bus.STORE  = 1'b1;
        bus.RUN_SW = 1'b1;
        n = 0;
        while (bus.RUNNING !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("same_latency", n, 8);
        bus.STORE = 1'b0;
        repeat (10) tick();
        check("same_running", bus.RUNNING, 1);
        check("same_lptr",    bus.LPTR,    1);
        bus.ADD = 8'h00; #1; check("same_ins_0", bus.Ins, 8'hA5);
        bus.ADD = 8'h01; #1; check("same_ins_1", bus.Ins, 8'h00);

        // Reset at clr_cnt = 100 restarts a full-length clear; RUN_SW stays high.
        do_reset();
        check("midrst_running",   bus.RUNNING,   0);
        check("midrst_cpu_reset", bus.CPU_RESET, 1);
        check("midrst_lptr",      bus.LPTR,      0);
        repeat (100) tick();
        do_reset();
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (n == 0 && bus.RUNNING === 1'b1) n = i;
        end
        check("midrst_run_cycle", n, 258);
        bus.ADD = 8'h00; #1; check("midrst_ins_0", bus.Ins, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
